// File: rtl/uart_print_arbiter_pkg.sv
// rtl/uart_print_arbiter_pkg.sv - shared types and constants for the UART print arbiter
package uart_print_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_t;

    localparam int PR_MSG_W  = 64;
    localparam int MAX_REQ   = 8;
    localparam int ID_W      = 3;

    // One 8-char message at 115200 baud, 10 bits per frame, is about 35k cycles at 50 MHz;
    // the default watchdog leaves ample margin above that.
    localparam int CLK_HZ        = 50_000_000;
    localparam int BAUD          = 115_200;
    localparam int FRAME_BITS    = 10;
    localparam int MSG_CHARS     = 8;
    localparam int MIN_TIMEOUT   = (CLK_HZ / BAUD) * FRAME_BITS * MSG_CHARS;
    localparam int TIMEOUT_DFLT  = 2_000_000;

endpackage

// File: rtl/uart_print_arbiter_rr_pick.sv
// rtl/uart_print_arbiter_rr_pick.sv - combinational round-robin first-set-bit search after last grant
module uart_print_arbiter_rr_pick
    import uart_print_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] last_i,
    output logic            valid_o,
    output logic [ID_W-1:0] idx_o
);

    logic [MAX_REQ-1:0] req_pad;
    logic               hi_valid;
    logic               lo_valid;
    logic [ID_W-1:0]    hi_idx;
    logic [ID_W-1:0]    lo_idx;

    // Lowest set bit above last_i wins; otherwise wrap to the lowest set bit at or below it.
    always_comb begin
        req_pad  = MAX_REQ'(req_i);
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_pad[j]) begin
                if (ID_W'(j) > last_i) begin
                    hi_valid = 1'b1;
                    hi_idx   = ID_W'(j);
                end else begin
                    lo_valid = 1'b1;
                    lo_idx   = ID_W'(j);
                end
            end
        end
        valid_o = hi_valid | lo_valid;
        idx_o   = hi_valid ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/uart_print_arbiter.sv
// rtl/uart_print_arbiter.sv - round-robin arbiter sharing one 8-char UART printer with a watchdog
module uart_print_arbiter
    import uart_print_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MSG_W   = PR_MSG_W,
    parameter int HOLDOFF = 2,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_h,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*MSG_W-1:0] i_data,
    output logic [N_REQ-1:0]       o_ack,
    output logic [MSG_W-1:0]       o_pr_data,
    output logic                   o_pr_we,
    input  logic                   i_pr_ready,
    output logic                   o_busy,
    output logic [ID_W-1:0]        o_gnt_id,
    output logic                   o_err
);

    localparam int CNT_W = $clog2((TIMEOUT > HOLDOFF ? TIMEOUT : HOLDOFF) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    logic [MSG_W-1:0]  data_d;
    logic [N_REQ-1:0]  ack_d;

    uart_print_arbiter_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req_i   (i_req),
        .last_i  (o_gnt_id),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        data_d = '0;
        ack_d  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx == ID_W'(k)) begin
                data_d   = i_data[k*MSG_W +: MSG_W];
                ack_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_h) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            o_ack     <= '0;
            o_pr_we   <= 1'b0;
            o_pr_data <= '0;
            o_busy    <= 1'b0;
            o_gnt_id  <= ID_W'(N_REQ - 1);
            o_err     <= 1'b0;
        end else begin
            o_ack   <= '0;
            o_pr_we <= 1'b0;
            o_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (i_pr_ready && pick_valid) begin
                        o_pr_data <= data_d;
                        o_pr_we   <= 1'b1;
                        o_ack     <= ack_d;
                        o_gnt_id  <= pick_idx;
                        o_busy    <= 1'b1;
                        state_q   <= ST_HOLD;
                    end
                end
                // Printer ready is still stale right after the strobe, so it is not looked at here.
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_RDY;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_RDY: begin
                    if (i_pr_ready) begin
                        cnt_q   <= '0;
                        o_busy  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == WDOG_LAST) begin
                        cnt_q   <= '0;
                        o_err   <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_print_arbiter.sv
// tb/tb_uart_print_arbiter.sv - scoreboard bench for uart_print_arbiter with printer and requester models
module tb_uart_print_arbiter;

    localparam int N    = 4;
    localparam int MW   = 64;
    localparam int HOLD = 2;
    localparam int TMO  = 512;

    typedef struct {
        int            id;
        logic [MW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [MW-1:0]   dat [N];
    logic [N*MW-1:0] data_bus;
    logic [N-1:0]    ack;
    logic [MW-1:0]   pr_data;
    logic            pr_we;
    logic            pr_ready;
    logic            busy;
    logic [2:0]      gnt_id;
    logic            err;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_last;
    int   rereq_left [N];
    int   cyc = 0;
    int   n_we = 0;
    int   n_err = 0;
    logic we_now = 1'b0;
    logic err_now = 1'b0;
    int   pr_t = 100000;
    int   pr_busy = 10;
    logic pr_stuck = 1'b0;
    logic pr_force_low = 1'b0;

    assign data_bus = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    uart_print_arbiter #(
        .N_REQ   (N),
        .MSG_W   (MW),
        .HOLDOFF (HOLD),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk      (clk),
        .i_rst_h    (rst),
        .i_req      (req),
        .i_data     (data_bus),
        .o_ack      (ack),
        .o_pr_data  (pr_data),
        .o_pr_we    (pr_we),
        .i_pr_ready (pr_ready),
        .o_busy     (busy),
        .o_gnt_id   (gnt_id),
        .o_err      (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: requests raised together are served in round-robin order after the last winner;
    // a requester with re-requests left stays in the pending set.
    task automatic push_batch(input logic [N-1:0] mask);
        int   cnt [N];
        int   left;
        exp_t e;
        left = 0;
        for (int k = 0; k < N; k++) begin
            cnt[k] = mask[k] ? 1 + rereq_left[k] : 0;
            left += cnt[k];
        end
        while (left > 0) begin
            for (int i = 1; i <= N; i++) begin
                int id;
                id = (m_last + i) % N;
                if (cnt[id] > 0) begin
                    cnt[id]--;
                    left--;
                    e.id   = id;
                    e.data = dat[id];
                    exp_q.push_back(e);
                    m_last = id;
                    break;
                end
            end
        end
    endtask

    // One cycle: requesters drop on ack, printer holds ready for 2 cycles after a strobe then goes busy.
    task automatic tick();
        @(negedge clk);
        cyc++;
        we_now  = pr_we;
        err_now = err;
        if (pr_we) n_we++;
        if (err) n_err++;
        for (int k = 0; k < N; k++) begin
            if (ack[k]) begin
                if (rereq_left[k] > 0) rereq_left[k]--;
                else req[k] = 1'b0;
            end
        end
        if (pr_we) pr_t = 0;
        else if (pr_t < 100000) pr_t++;
        pr_ready = !pr_force_low && ((pr_t < 2) || (!pr_stuck && pr_t >= 2 + pr_busy));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && req == '0 && !busy) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle_within_budget"}, 64'(n >= budget), 64'd0);
    endtask

    task automatic wait_we(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!we_now && n < budget);
        check({name, "_we_within_budget"}, 64'(we_now), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},    64'(ack),     64'd0);
        check({tag, "_we"},     64'(pr_we),   64'd0);
        check({tag, "_data"},   pr_data,      64'd0);
        check({tag, "_busy"},   64'(busy),    64'd0);
        check({tag, "_gnt_id"}, 64'(gnt_id),  64'(N - 1));
        check({tag, "_err"},    64'(err),     64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pr_we) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_we", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_gnt_id", 64'(gnt_id), 64'(e.id));
                    check("sb_ack", 64'(ack), 64'd1 << e.id);
                    check("sb_data", pr_data, e.data);
                    check("sb_busy_at_we", 64'(busy), 64'd1);
                end
            end else if (ack != '0) begin
                check("sb_stray_ack", 64'(ack), 64'd0);
            end
            if (err && pr_we) check("sb_err_with_we", 64'd1, 64'd0);
        end
    end

    initial begin
        int w_cyc;
        int n0;
        int e0;
        rst      = 1'b1;
        req      = '0;
        pr_ready = 1'b1;
        m_last   = N - 1;
        for (int k = 0; k < N; k++) begin
            dat[k]        = '0;
            rereq_left[k] = 0;
        end
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // single request, 1-cycle latency
        dat[2] = 64'h544553545F4F4B0A;
        push_batch(4'b0100);
        req = 4'b0100;
        tick();
        check("single_we_latency", 64'(we_now), 64'd1);
        check("single_gnt_id", 64'(gnt_id), 64'd2);
        wait_idle("single", 200);

        // rotation from reset with all requests held, requester 0 re-requests once
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last = N - 1;
        for (int k = 0; k < N; k++) dat[k] = {$urandom, $urandom};
        pr_busy = 100;
        rereq_left[0] = 1;
        n0 = n_we;
        push_batch(4'b1111);
        req = 4'b1111;
        wait_idle("rotation", 2000);
        check("rotation_we_count", 64'(n_we - n0), 64'd5);

        // printer not ready holds off every grant
        pr_busy = 10;
        pr_force_low = 1'b1;
        tick();
        push_batch(4'b0010);
        req = 4'b0010;
        n0 = n_we;
        repeat (50) tick();
        check("notready_no_we", 64'(n_we - n0), 64'd0);
        pr_force_low = 1'b0;
        tick();
        check("notready_we_not_yet", 64'(we_now), 64'd0);
        tick();
        check("notready_we_next_cycle", 64'(we_now), 64'd1);
        wait_idle("notready", 200);

        // holdoff: ready stays high 2 cycles after strobe, then long busy with a pending request
        pr_busy = 300;
        push_batch(4'b1000);
        req = 4'b1000;
        wait_we("holdoff_first", 20);
        n0 = n_we;
        push_batch(4'b0001);
        req[0] = 1'b1;
        for (int i = 0; i < 10 && pr_ready; i++) tick();
        for (int i = 0; i < 400 && !pr_ready; i++) tick();
        check("holdoff_no_extra_we", 64'(n_we - n0), 64'd0);
        tick();
        check("holdoff_busy_fall", 64'(busy), 64'd0);
        check("holdoff_no_early_we", 64'(we_now), 64'd0);
        tick();
        check("holdoff_regrant", 64'(we_now), 64'd1);
        wait_idle("holdoff", 600);

        // watchdog: printer never returns ready
        pr_busy = 20;
        pr_stuck = 1'b1;
        push_batch(4'b0100);
        req = 4'b0100;
        wait_we("wdog_first", 20);
        w_cyc = cyc;
        e0 = n_err;
        push_batch(4'b0010);
        req[1] = 1'b1;
        for (int i = 0; i < HOLD + TMO + 50 && !err_now; i++) tick();
        check("wdog_err_delay", 64'(cyc - w_cyc), 64'(HOLD + TMO));
        check("wdog_busy_fall", 64'(busy), 64'd0);
        n0 = n_we;
        repeat (10) tick();
        check("wdog_no_grant_while_stuck", 64'(n_we - n0), 64'd0);
        check("wdog_single_err", 64'(n_err - e0), 64'd1);
        pr_stuck = 1'b0;
        wait_idle("wdog", 300);

        // randomized batches
        for (int b = 0; b < 20; b++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                dat[k]        = {$urandom, $urandom};
                rereq_left[k] = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end
            pr_busy = $urandom_range(3, 60);
            push_batch(mask);
            req = mask;
            wait_idle("random", 2000);
        end

        // reset while waiting for printer ready
        pr_busy = 100;
        push_batch(4'b0010);
        req = 4'b0010;
        wait_we("midrst", 20);
        repeat (20) tick();
        e0 = n_err;
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        m_last = N - 1;
        repeat (HOLD + TMO + 20) tick();
        check("midrst_no_err", 64'(n_err - e0), 64'd0);
        pr_busy = 5;
        for (int k = 0; k < N; k++) begin
            dat[k]        = {$urandom, $urandom};
            rereq_left[k] = 0;
        end
        push_batch(4'b1111);
        req = 4'b1111;
        wait_idle("post_rst", 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
